// File: rtl/pll_lock_supervisor.sv
// Per-channel PLL/MMCM lock supervisor: drives PLL RST, gates output-buffer CE once lock has
// been stable, retries failed locks, latches a fault after too many retries, counts lock losses.
module pll_lock_supervisor #(
  parameter int unsigned NUM_PLLS            = 3,
  parameter int unsigned RESET_PULSE_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_PLLS-1:0]   pll_lock,
  input  logic [NUM_PLLS-1:0]   force_reset,
  output logic [NUM_PLLS-1:0]   pll_rst,
  output logic [NUM_PLLS-1:0]   clk_en,
  output logic [NUM_PLLS-1:0]   pll_fault,
  output logic [8*NUM_PLLS-1:0] relock_count,
  output logic                  all_ready
);

  localparam int unsigned MaxRstTo = (RESET_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                     RESET_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MaxCnt   = (MaxRstTo > LOCK_STABLE_CYCLES) ?
                                     MaxRstTo : LOCK_STABLE_CYCLES;
  localparam int unsigned CntW     = $clog2(MaxCnt + 1);
  localparam int unsigned RetW     = $clog2(MAX_RETRIES + 1);

  localparam logic [CntW-1:0] RstLast     = CntW'(RESET_PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RetW-1:0] RetryLast   = RetW'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    StReset,
    StWaitLock,
    StStable,
    StRun,
    StFault
  } state_e;

  // LOCKED is asynchronous to clk; nothing downstream looks at the raw input.
  logic [NUM_PLLS-1:0] lock_meta_q, lock_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= '0;
      lock_s_q    <= '0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  for (genvar i = 0; i < NUM_PLLS; i++) begin : g_ch
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [RetW-1:0] retry_q, retry_d;
    logic [7:0]      relock_q, relock_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= StReset;
        cnt_q    <= '0;
        retry_q  <= '0;
        relock_q <= '0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        retry_q  <= retry_d;
        relock_q <= relock_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CntW'(1);
      retry_d  = retry_q;
      relock_d = relock_q;
      if (force_reset[i]) begin
        // Restart wins over any lock or timeout event in the same cycle.
        state_d = StReset;
        cnt_d   = '0;
        retry_d = '0;
      end else begin
        unique case (state_q)
          StReset: begin
            if (cnt_q == RstLast) begin
              state_d = StWaitLock;
              cnt_d   = '0;
            end
          end
          StWaitLock: begin
            if (lock_s_q[i]) begin
              state_d = StStable;
              cnt_d   = '0;
            end else if (cnt_q == TimeoutLast) begin
              cnt_d   = '0;
              retry_d = retry_q + RetW'(1);
              state_d = (retry_q == RetryLast) ? StFault : StReset;
            end
          end
          StStable: begin
            if (!lock_s_q[i]) begin
              state_d = StWaitLock;
              cnt_d   = '0;
            end else if (cnt_q == StableLast) begin
              state_d = StRun;
              cnt_d   = '0;
              retry_d = '0;
            end
          end
          StRun: begin
            cnt_d = '0;
            if (!lock_s_q[i]) begin
              state_d = StReset;
              if (relock_q != 8'hff) relock_d = relock_q + 8'd1;
            end
          end
          StFault: cnt_d = '0;
          default: begin
            state_d = StReset;
            cnt_d   = '0;
          end
        endcase
      end
    end

    assign pll_rst[i]              = (state_q == StReset) || (state_q == StFault);
    assign clk_en[i]               = (state_q == StRun);
    assign pll_fault[i]            = (state_q == StFault);
    assign relock_count[8*i +: 8]  = relock_q;
  end

  logic all_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) all_ready_q <= 1'b0;
    else        all_ready_q <= &clk_en;
  end

  assign all_ready = all_ready_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: stimulus queues expected values per cycle, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_pll_lock_supervisor;

  localparam int N = 3;
  localparam int R = 16;
  localparam int T = 200;
  localparam int S = 32;
  localparam int M = 3;

  localparam int KRst = 0, KEn = 1, KFault = 2, KRelock = 3, KReady = 4;

  logic           clk, rst_n;
  logic [N-1:0]   pll_lock, force_reset;
  logic [N-1:0]   pll_rst, clk_en, pll_fault;
  logic [8*N-1:0] relock_count;
  logic           all_ready;

  pll_lock_supervisor #(
    .NUM_PLLS            (N),
    .RESET_PULSE_CYCLES  (R),
    .LOCK_TIMEOUT_CYCLES (T),
    .LOCK_STABLE_CYCLES  (S),
    .MAX_RETRIES         (M)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_lock     (pll_lock),
    .force_reset  (force_reset),
    .pll_rst      (pll_rst),
    .clk_en       (clk_en),
    .pll_fault    (pll_fault),
    .relock_count (relock_count),
    .all_ready    (all_ready)
  );

  typedef struct {
    int    due;
    string name;
    int    kind;
    int    ch;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   mi;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic int actual(input int kind, input int ch);
    case (kind)
      KRst:    return int'(pll_rst[ch]);
      KEn:     return int'(clk_en[ch]);
      KFault:  return int'(pll_fault[ch]);
      KRelock: return int'(relock_count[8*ch +: 8]);
      default: return int'(all_ready);
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    mi = 0;
    while (mi < sb.size()) begin
      if (sb[mi].due == cyc) begin
        n_checks++;
        if (actual(sb[mi].kind, sb[mi].ch) != sb[mi].val) begin
          n_errors++;
          $display("FAIL %s ch%0d cycle %0d: got %0d expected %0d", sb[mi].name, sb[mi].ch,
                   cyc, actual(sb[mi].kind, sb[mi].ch), sb[mi].val);
        end
        sb.delete(mi);
      end else begin
        mi++;
      end
    end
  end

  task automatic exp_at(input string name, input int kind, input int ch, input int due,
                        input int val);
    exp_t e;
    e.due  = due;
    e.name = name;
    e.kind = kind;
    e.ch   = ch;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int c0, c1, c2, c3, c4, c5, c6, c7, b;

  initial begin
    rst_n       = 1'b0;
    pll_lock    = '0;
    force_reset = '0;
    step(3);

    // Reset values
    for (int ch = 0; ch < N; ch++) begin
      exp_at("rst_pll_rst", KRst, ch, cyc, 1);
      exp_at("rst_clk_en", KEn, ch, cyc, 0);
      exp_at("rst_fault", KFault, ch, cyc, 0);
      exp_at("rst_relock", KRelock, ch, cyc, 0);
    end
    exp_at("rst_all_ready", KReady, 0, cyc, 0);

    // Startup: reset pulse, lock 100 cycles later
    rst_n = 1'b1;
    c0 = cyc;
    exp_at("start_rst_hi", KRst, 0, c0 + R - 1, 1);
    exp_at("start_rst_lo", KRst, 0, c0 + R, 0);
    exp_at("start_rst_lo", KRst, 2, c0 + R, 0);
    step(100);
    c1 = cyc;
    pll_lock = '1;
    exp_at("start_en_early", KEn, 0, c1 + 2 + S, 0);
    exp_at("start_en", KEn, 0, c1 + 3 + S, 1);
    exp_at("start_en", KEn, 1, c1 + 3 + S, 1);
    exp_at("start_ready_early", KReady, 0, c1 + 3 + S, 0);
    exp_at("start_ready", KReady, 0, c1 + 4 + S, 1);
    step(S + 10);

    // Lock loss in RUN on channel 0
    c2 = cyc;
    pll_lock[0] = 1'b0;
    exp_at("loss_en_hold", KEn, 0, c2 + 2, 1);
    exp_at("loss_en_drop", KEn, 0, c2 + 3, 0);
    exp_at("loss_relock0", KRelock, 0, c2 + 2, 0);
    exp_at("loss_relock1", KRelock, 0, c2 + 3, 1);
    exp_at("loss_ready_hold", KReady, 0, c2 + 3, 1);
    exp_at("loss_ready_drop", KReady, 0, c2 + 4, 0);
    exp_at("loss_rst_start", KRst, 0, c2 + 3, 1);
    exp_at("loss_rst_end", KRst, 0, c2 + 18, 1);
    exp_at("loss_rst_off", KRst, 0, c2 + 19, 0);
    exp_at("loss_other_en", KEn, 1, c2 + 5, 1);
    step(30);

    // Relock with a one-cycle glitch during the stable count
    c3 = cyc;
    pll_lock[0] = 1'b1;
    step(10);
    pll_lock[0] = 1'b0;
    step(1);
    pll_lock[0] = 1'b1;
    exp_at("glitch_en_nominal", KEn, 0, c3 + 3 + S, 0);
    exp_at("glitch_en_early", KEn, 0, c3 + 13 + S, 0);
    exp_at("glitch_en", KEn, 0, c3 + 14 + S, 1);
    exp_at("glitch_ready", KReady, 0, c3 + 15 + S, 1);
    exp_at("glitch_relock", KRelock, 0, c3 + 14 + S, 1);
    step(S + 13);

    // Channel 1 never locks
    c4 = cyc;
    pll_lock[1]    = 1'b0;
    force_reset[1] = 1'b1;
    exp_at("nolock_ready", KReady, 0, c4 + 2, 0);
    exp_at("nolock_p1_hi", KRst, 1, c4 + 16, 1);
    exp_at("nolock_p1_lo", KRst, 1, c4 + 17, 0);
    exp_at("nolock_w1_end", KRst, 1, c4 + 16 + T, 0);
    exp_at("nolock_p2_hi", KRst, 1, c4 + 17 + T, 1);
    exp_at("nolock_p2_lo", KRst, 1, c4 + 33 + T, 0);
    exp_at("nolock_p3_hi", KRst, 1, c4 + 33 + 2*T, 1);
    exp_at("nolock_w3_end", KRst, 1, c4 + 48 + 3*T, 0);
    exp_at("nolock_no_fault", KFault, 1, c4 + 48 + 3*T, 0);
    exp_at("nolock_fault", KFault, 1, c4 + 49 + 3*T, 1);
    exp_at("nolock_fault_rst", KRst, 1, c4 + 49 + 3*T, 1);
    exp_at("nolock_fault_held", KFault, 1, c4 + 99 + 3*T, 1);
    exp_at("nolock_rst_held", KRst, 1, c4 + 99 + 3*T, 1);
    exp_at("nolock_other_en0", KEn, 0, c4 + 49 + 3*T, 1);
    exp_at("nolock_other_en2", KEn, 2, c4 + 49 + 3*T, 1);
    exp_at("nolock_relock", KRelock, 1, c4 + 60, 0);
    step(1);
    force_reset[1] = 1'b0;
    step(109 + 3*T);

    // Recovery: force_reset in FAULT together with a lock edge
    c5 = cyc;
    pll_lock[1]    = 1'b1;
    force_reset[1] = 1'b1;
    exp_at("recov_fault_before", KFault, 1, c5, 1);
    exp_at("recov_fault_clr", KFault, 1, c5 + 1, 0);
    exp_at("recov_rst", KRst, 1, c5 + 16, 1);
    exp_at("recov_rst_off", KRst, 1, c5 + 17, 0);
    exp_at("recov_en_early", KEn, 1, c5 + 17 + S, 0);
    exp_at("recov_en", KEn, 1, c5 + 18 + S, 1);
    exp_at("recov_ready", KReady, 0, c5 + 19 + S, 1);
    exp_at("recov_relock_kept", KRelock, 0, c5 + 1, 1);
    step(1);
    force_reset[1] = 1'b0;
    step(S + 30);

    // force_reset coinciding with a synchronised lock loss: no relock increment
    c6 = cyc;
    pll_lock[0] = 1'b0;
    step(2);
    force_reset[0] = 1'b1;
    exp_at("frc_en_hold", KEn, 0, c6 + 2, 1);
    exp_at("frc_en_drop", KEn, 0, c6 + 3, 0);
    exp_at("frc_rst", KRst, 0, c6 + 3, 1);
    exp_at("frc_relock", KRelock, 0, c6 + 3, 1);
    exp_at("frc_relock_late", KRelock, 0, c6 + 10, 1);
    exp_at("frc_en_early", KEn, 0, c6 + 19 + S, 0);
    exp_at("frc_en", KEn, 0, c6 + 20 + S, 1);
    step(1);
    force_reset[0] = 1'b0;
    pll_lock[0]    = 1'b1;
    step(S + 25);

    // Async reset mid-RUN
    exp_at("pre_async_en", KEn, 0, cyc, 1);
    step(1);
    #1;
    rst_n = 1'b0;
    exp_at("async_rst0", KRst, 0, cyc, 1);
    exp_at("async_rst2", KRst, 2, cyc, 1);
    exp_at("async_en0", KEn, 0, cyc, 0);
    exp_at("async_en1", KEn, 1, cyc, 0);
    exp_at("async_ready", KReady, 0, cyc, 0);
    exp_at("async_relock", KRelock, 0, cyc, 0);
    exp_at("async_fault", KFault, 1, cyc, 0);
    step(2);
    rst_n = 1'b1;
    c7 = cyc;
    exp_at("rerun_en_early", KEn, 2, c7 + 16 + S, 0);
    exp_at("rerun_en", KEn, 2, c7 + 17 + S, 1);
    exp_at("rerun_ready", KReady, 0, c7 + 18 + S, 1);
    step(S + 20);

    // 300 lock losses on channel 2: counter saturates at 255
    for (int k = 1; k <= 300; k++) begin
      b = cyc;
      pll_lock[2] = 1'b0;
      if (k <= 2 || k % 50 == 0 || k >= 254)
        exp_at("sat_relock", KRelock, 2, b + 3, (k > 255) ? 255 : k);
      step(3);
      pll_lock[2] = 1'b1;
      step(S + 27);
    end
    exp_at("sat_final", KRelock, 2, cyc + 1, 255);
    exp_at("sat_en", KEn, 2, cyc + 1, 1);
    exp_at("sat_other_relock", KRelock, 0, cyc + 1, 0);
    exp_at("sat_ready", KReady, 0, cyc + 1, 1);
    step(20);

    n_checks++;
    if (relock_count[8*2 +: 8] !== 8'd255) begin
      n_errors++;
      $display("FAIL end_relock2: got %0d expected 255", relock_count[8*2 +: 8]);
    end
    n_checks++;
    if (relock_count[7:0] !== 8'd0) begin
      n_errors++;
      $display("FAIL end_relock0: got %0d expected 0", relock_count[7:0]);
    end
    n_checks++;
    if (clk_en[2] !== 1'b1) begin
      n_errors++;
      $display("FAIL end_en2: got %0b expected 1", clk_en[2]);
    end
    n_checks++;
    if (all_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL end_ready: got %0b expected 1", all_ready);
    end

    while (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s ch%0d: never sampled, expected %0d due cycle %0d", sb[0].name,
               sb[0].ch, sb[0].val, sb[0].due);
      void'(sb.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
